// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the register file's single write port (written on the falling clock
// edge) between two writers:
//   port A - main pipeline writeback, highest priority, never back-pressured;
//   port B - long-latency results, valid/ready, buffered in a small FIFO.
// Also publishes a pending-write mask and a decode read-hazard stall, and it
// raises a starvation stall request when port-B results wait too long.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   a_we, a_wa, a_wd           pipeline writeback
//   b_valid, b_ready, b_wa, b_wd  long-latency result handshake
//   ra1, ra2                   decode read addresses
//   rf_we3, rf_wa3, rf_wd3     register-file write port (combinational)
//   pending_mask               bit r: a live queued entry targets register r
//   stall_rd                   a decode read hits a pending register
//   stall_req                  asks the hazard unit to hold off port A
//   drop_r15                   one-cycle pulse: port-B write to R15 discarded
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_we,
  input  logic [3:0]  a_wa,
  input  logic [31:0] a_wd,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [3:0]  b_wa,
  input  logic [31:0] b_wd,
  input  logic [3:0]  ra1,
  input  logic [3:0]  ra2,
  output logic        rf_we3,
  output logic [3:0]  rf_wa3,
  output logic [31:0] rf_wd3,
  output logic [14:0] pending_mask,
  output logic        stall_rd,
  output logic        stall_req,
  output logic        drop_r15
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic        live;
    logic [3:0]  wa;
    logic [31:0] wd;
  } entry_t;

  entry_t          fifo_r [DEPTH];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;
  logic [SW-1:0]   starve_r;
  logic            stall_req_r;
  logic            drop_r15_r;

  logic            empty_s;
  logic            accept_s;
  logic            push_s;
  logic            drop_s;
  logic            a_write_s;
  logic            pop_s;
  logic [SW-1:0]   starve_next_s;
  logic [14:0]     pend_s;
  logic [15:0]     pend16_s;
  entry_t          head_s;

  assign empty_s   = (count_r == '0);
  assign b_ready   = !reset && (count_r < DEPTH_C);
  assign accept_s  = b_valid && b_ready;
  assign push_s    = accept_s && (b_wa != 4'd15);
  assign drop_s    = accept_s && (b_wa == 4'd15);
  assign a_write_s = a_we && (a_wa != 4'd15);
  // A idle is the only time the head drains; dead (squashed) heads still cost a slot.
  assign pop_s     = !a_we && !empty_s;
  assign head_s    = fifo_r[head_r];

  assign stall_req = stall_req_r;
  assign drop_r15  = drop_r15_r;

  // Write-port mux: A first, otherwise the FIFO head; visible in-cycle for the negedge write.
  always_comb begin
    rf_we3 = 1'b0;
    rf_wa3 = 4'd0;
    rf_wd3 = 32'd0;
    if (reset) begin
      rf_we3 = 1'b0;
    end else if (a_we) begin
      rf_we3 = (a_wa != 4'd15);
      rf_wa3 = a_wa;
      rf_wd3 = a_wd;
    end else if (!empty_s) begin
      rf_we3 = head_s.live;
      rf_wa3 = head_s.wa;
      rf_wd3 = head_s.wd;
    end else begin
      rf_we3 = 1'b0;
    end
  end

  // Pending-write mask: popped and squashed slots carry live = 0, so every live slot is queued.
  always_comb begin
    pend_s = 15'd0;
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_r[i].live && (fifo_r[i].wa == 4'(r))) begin
          pend_s[r] = 1'b1;
        end else begin
          pend_s[r] = pend_s[r];
        end
      end
    end
  end

  assign pending_mask = pend_s;
  assign pend16_s     = {1'b0, pend_s};
  assign stall_rd     = ((ra1 != 4'd15) && pend16_s[ra1]) ||
                        ((ra2 != 4'd15) && pend16_s[ra2]);

  // Starve counter next value; stall_req registers this so it tracks the counter with no lag.
  always_comb begin
    starve_next_s = starve_r;
    if (empty_s || pop_s) begin
      starve_next_s = '0;
    end else if (a_we && (starve_r < LIMIT_C)) begin
      starve_next_s = starve_r + SW'(1'b1);
    end else begin
      starve_next_s = starve_r;
    end
  end

  // FIFO storage, pointers, WAW squash, starve tracking and drop pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= '0;
      end
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      starve_r    <= '0;
      stall_req_r <= 1'b0;
      drop_r15_r  <= 1'b0;
    end else begin
      // A is younger than anything already queued for the same register.
      if (a_write_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (fifo_r[i].wa == a_wa) begin
            fifo_r[i].live <= 1'b0;
          end
        end
      end
      if (pop_s) begin
        fifo_r[head_r].live <= 1'b0;
        head_r              <= head_r + PW'(1'b1);
      end
      // Placed after the squash so an entry pushed this cycle stays live.
      if (push_s) begin
        fifo_r[tail_r] <= {1'b1, b_wa, b_wd};
        tail_r         <= tail_r + PW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
      starve_r    <= starve_next_s;
      stall_req_r <= (starve_next_s >= LIMIT_C);
      drop_r15_r  <= drop_s;
    end
  end

endmodule
